// File: rtl/mult_serial_sched_if.sv
// Handshake and serial-multiplier bundle between the scheduler and its environment.
// slave = scheduler side, master = requesters/consumer/multiplier side.
interface mult_serial_sched_if;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_a, req1_b;
  logic       res_valid, res_ready, res_id;
  logic [7:0] res_p;
  logic       M_CLR, M_A, M_B, M_O;
  logic       busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready, M_O,
    output req0_ready, req1_ready, res_valid, res_id, res_p, M_CLR, M_A, M_B, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready, M_O,
    input  req0_ready, req1_ready, res_valid, res_id, res_p, M_CLR, M_A, M_B, busy
  );
endinterface

// File: rtl/mult_serial_sched.sv
// Round-robin scheduler for a shared 4-bit serial multiplier: clear, stream operands
// LSB-first, deserialize the 8-bit product and return it tagged with the requester id.
module mult_serial_sched #(
  parameter int O_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  mult_serial_sched_if.slave bus
);
  localparam int         NUM_REQ = 2;
  localparam logic [3:0] LAT_K   = 4'(O_LAT);
  localparam logic [3:0] LAST_K  = 4'(7 + O_LAT);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_SHIFT, S_DONE} state_t;

  state_t     r_state;
  logic       r_last, r_id, r_res_id, r_res_valid, r_mclr, r_ma, r_mb, r_busy;
  logic [3:0] r_a, r_b, r_k;
  logic [6:0] r_prod;
  logic [7:0] r_res_p;

  logic [NUM_REQ-1:0]      w_vld, w_rdy;
  logic [NUM_REQ-1:0][3:0] w_a, w_b;
  logic                    w_gnt, w_xfer, w_cap, w_nx_a, w_nx_b;
  logic [3:0]              w_k_nx;

  assign w_vld = {bus.req1_valid, bus.req0_valid};
  assign w_a   = {bus.req1_a, bus.req0_a};
  assign w_b   = {bus.req1_b, bus.req0_b};

  // A lone requester wins outright; on a tie (or no request) the pointer picks
  // the one not granted last, so exactly one ready is up in IDLE.
  always_comb begin
    w_gnt = ~r_last;
    case (w_vld)
      2'b01:   w_gnt = 1'b0;
      2'b10:   w_gnt = 1'b1;
      default: w_gnt = ~r_last;
    endcase
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rdy
    assign w_rdy[g] = i_rst_n && (r_state == S_IDLE) && (w_gnt == 1'(g));
  end

  assign w_xfer = |(w_vld & w_rdy);

  // Product bits start arriving O_LAT cycles into SHIFT.
  if (O_LAT == 0) begin : g_cap0
    assign w_cap = 1'b1;
  end else begin : g_capn
    assign w_cap = (r_k >= LAT_K);
  end

  assign w_k_nx = r_k + 4'd1;
  assign w_nx_a = (w_k_nx < 4'd4) ? r_a[w_k_nx[1:0]] : 1'b0;
  assign w_nx_b = (w_k_nx < 4'd4) ? r_b[w_k_nx[1:0]] : 1'b0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_k         <= '0;
      r_prod      <= '0;
      r_res_p     <= '0;
      r_res_id    <= 1'b0;
      r_res_valid <= 1'b0;
      r_mclr      <= 1'b0;
      r_ma        <= 1'b0;
      r_mb        <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_a     <= w_a[w_gnt];
            r_b     <= w_b[w_gnt];
            r_id    <= w_gnt;
            r_last  <= w_gnt;
            r_prod  <= '0;
            r_mclr  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_CLR;
          end
        end
        S_CLR: begin
          r_mclr  <= 1'b0;
          r_k     <= '0;
          r_ma    <= r_a[0];
          r_mb    <= r_b[0];
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_cap) r_prod <= {bus.M_O, r_prod[6:1]};
          if (r_k == LAST_K) begin
            // Final capture is product bit 7; publish straight from the shifter.
            r_res_p     <= {bus.M_O, r_prod};
            r_res_id    <= r_id;
            r_res_valid <= 1'b1;
            r_ma        <= 1'b0;
            r_mb        <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_k  <= w_k_nx;
            r_ma <= w_nx_a;
            r_mb <= w_nx_b;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_rdy[0];
  assign bus.req1_ready = w_rdy[1];
  assign bus.res_valid  = r_res_valid;
  assign bus.res_id     = r_res_id;
  assign bus.res_p      = r_res_p;
  assign bus.M_CLR      = r_mclr;
  assign bus.M_A        = r_ma;
  assign bus.M_B        = r_mb;
  assign bus.busy       = r_busy;
endmodule
